// File: rtl/addsub_result_fifo_if.sv
// Handshake bundle between the add/sub result FIFO, its producer and its consumer.
// With ADDSUB_FIFO_DROPCNT_EN defined the bundle also carries the 8-bit drop counter.
interface addsub_result_fifo_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          in_valid;
    logic [DW-1:0] in_s;
    logic          in_cout;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_s;
    logic          out_cout;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          overflow;
`ifdef ADDSUB_FIFO_DROPCNT_EN
    logic [7:0]    drop_cnt;
`endif

    // master: producer/consumer side; slave: the FIFO
    modport master (
        output in_valid, in_s, in_cout, out_ready,
        input  out_valid, out_s, out_cout, level, full, empty, overflow
`ifdef ADDSUB_FIFO_DROPCNT_EN
        , input drop_cnt
`endif
    );

    modport slave (
        input  in_valid, in_s, in_cout, out_ready,
        output out_valid, out_s, out_cout, level, full, empty, overflow
`ifdef ADDSUB_FIFO_DROPCNT_EN
        , output drop_cnt
`endif
    );
endinterface

// File: rtl/addsub_result_fifo.sv
// Result FIFO behind the add/sub stage: registered first-word-fall-through head, drop tracking.
// Optional macro ADDSUB_FIFO_DROPCNT_EN adds a saturating 8-bit drop counter.
module addsub_result_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    addsub_result_fifo_if.slave   fifo_if
);
    localparam int WW = DW + 1;

    logic [WW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [AW:0]   mem_cnt;
    logic [WW-1:0] head_q, head_d;
    logic [WW-1:0] in_word;
    logic          out_valid_q, out_valid_d;
    logic          full, pop, push, drop, mem_wr;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign in_word = {fifo_if.in_cout, fifo_if.in_s};

    // The head register holds the oldest entry; mem_q holds the rest (level - out_valid).
    always_comb begin
        full        = (level_q == (AW+1)'(DEPTH));
        pop         = out_valid_q && fifo_if.out_ready;
        push        = fifo_if.in_valid && (!full || pop);
        drop        = fifo_if.in_valid && full && !pop;
        mem_cnt     = level_q - (AW+1)'(out_valid_q);
        head_d      = head_q;
        out_valid_d = out_valid_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        mem_wr      = 1'b0;
        level_d     = level_q;

        if (!out_valid_q || pop) begin
            if (mem_cnt != '0) begin
                head_d      = mem_q[rd_ptr_q];
                rd_ptr_d    = rd_ptr_q + AW'(1);
                out_valid_d = 1'b1;
                mem_wr      = push;
            end else if (push) begin
                // Bypass straight into the head so an empty FIFO shows data after one edge
                head_d      = in_word;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            mem_wr = push;
        end

        if (mem_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            head_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            head_q      <= head_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem_q[wr_ptr_q] <= in_word;
        end
    end

`ifdef ADDSUB_FIFO_DROPCNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop ? sat_inc8(drop_cnt_q) : drop_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign fifo_if.drop_cnt = drop_cnt_q;
    assign fifo_if.overflow = (drop_cnt_q != 8'd0);
`else
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign fifo_if.overflow = overflow_q;
`endif

    assign fifo_if.out_valid = out_valid_q;
    assign fifo_if.out_s     = head_q[DW-1:0];
    assign fifo_if.out_cout  = head_q[DW];
    assign fifo_if.level     = level_q;
    assign fifo_if.full      = full;
    assign fifo_if.empty     = (level_q == '0);
endmodule

// File: tb/tb_addsub_result_fifo.sv
// Directed self-checking bench for addsub_result_fifo (default or ADDSUB_FIFO_DROPCNT_EN build).
module tb_addsub_result_fifo;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    addsub_result_fifo_if #(.DW(8), .AW(3)) bus ();

    addsub_result_fifo #(.DW(8), .DEPTH(8), .AW(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .fifo_if (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one edge; inputs and checks happen 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input logic [7:0] base, input int n);
        bus.in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.in_s    = base + 8'(i);
            bus.in_cout = 1'b0;
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q [$];
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_s      = '0;
        bus.in_cout   = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_s", 32'(bus.out_s), 0);
        chk("rst_cout", 32'(bus.out_cout), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        rst = 1'b0;
        step();

        // Single push, held without ready
        bus.in_valid = 1'b1;
        bus.in_s     = 8'h12;
        bus.in_cout  = 1'b0;
        step();
        bus.in_valid = 1'b0;
        chk("one_valid", 32'(bus.out_valid), 1);
        chk("one_s", 32'(bus.out_s), 32'h12);
        chk("one_level", 32'(bus.level), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_s", 32'(bus.out_s), 32'h12);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("one_drain_empty", 32'(bus.empty), 1);
        chk("one_drain_valid", 32'(bus.out_valid), 0);

        // Fill with 01..08, odd values carry cout=1
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.in_s    = 8'(i);
            bus.in_cout = i[0];
            step();
        end
        bus.in_valid = 1'b0;
        chk("fill_full", 32'(bus.full), 1);
        chk("fill_level", 32'(bus.level), 8);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_valid", 32'(bus.out_valid), 1);
            chk("drain_s", 32'(bus.out_s), 32'(i));
            chk("drain_cout", 32'(bus.out_cout), 32'(i & 1));
            step();
        end
        bus.out_ready = 1'b0;
        chk("drain_empty", 32'(bus.empty), 1);
        chk("drain_valid_lo", 32'(bus.out_valid), 0);

        // Full with simultaneous push/pop: level pinned at 8, nothing dropped
        push_run(8'h21, 8);
        chk("refill_level", 32'(bus.level), 8);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_s = 8'h31 + 8'(i);
            step();
            chk("pp_level", 32'(bus.level), 8);
            chk("pp_head", 32'(bus.out_s), 32'h22 + 32'(i));
        end
        chk("pp_ovf", 32'(bus.overflow), 0);

        // Full, no ready: three drops, contents preserved
        bus.out_ready = 1'b0;
        bus.in_s      = 8'hEE;
        step();
        chk("ovf_first", 32'(bus.overflow), 1);
        step();
        step();
        bus.in_valid = 1'b0;
        chk("ovf_level", 32'(bus.level), 8);
        chk("ovf_sticky", 32'(bus.overflow), 1);
`ifdef ADDSUB_FIFO_DROPCNT_EN
        chk("drop_cnt", 32'(bus.drop_cnt), 3);
`endif
        exp_q = '{8'h25, 8'h26, 8'h27, 8'h28, 8'h31, 8'h32, 8'h33, 8'h34};
        bus.out_ready = 1'b1;
        foreach (exp_q[i]) begin
            chk("keep_s", 32'(bus.out_s), 32'(exp_q[i]));
            step();
        end
        bus.out_ready = 1'b0;
        chk("keep_empty", 32'(bus.empty), 1);

        // Asynchronous reset mid-stream takes effect before the next edge
        push_run(8'h40, 3);
        chk("pre_rst_level", 32'(bus.level), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_level", 32'(bus.level), 0);
        chk("arst_empty", 32'(bus.empty), 1);
        chk("arst_valid", 32'(bus.out_valid), 0);
        chk("arst_ovf", 32'(bus.overflow), 0);
`ifdef ADDSUB_FIFO_DROPCNT_EN
        chk("arst_drop_cnt", 32'(bus.drop_cnt), 0);
`endif
        #1;
        rst = 1'b0;
        step();
        chk("post_rst_empty", 32'(bus.empty), 1);

        // Streaming: output follows input one edge later, no bubbles
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_s    = 8'(i);
            bus.in_cout = i[1];
            step();
            chk("stream_valid", 32'(bus.out_valid), 1);
            chk("stream_s", 32'(bus.out_s), 32'(i));
            chk("stream_cout", 32'(bus.out_cout), 32'((i >> 1) & 1));
            chk("stream_level", 32'(bus.level), 1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("stream_empty", 32'(bus.empty), 1);
        chk("stream_ovf", 32'(bus.overflow), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
